// File: rtl/sonar_capture_pkg.sv
// Shared types and constants for the sonar echo capture path.
package sonar_capture_pkg;

   typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, FLUSH} cap_state_t;

   localparam int          SAMPLE_W = 16;
   localparam int          WORD_W   = 32;
   localparam logic [15:0] OVF_MAX  = 16'hFFFF;

endpackage

// File: rtl/axis_buf2.sv
// Two-entry register FIFO with an AXI-Stream master side; it can accept
// a new entry while full provided the head is leaving in the same cycle.
module axis_buf2 #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              last_i,
   output logic              full_o,
   output logic [1:0]        level_o,
   output logic [DATA_W-1:0] m_tdata_o,
   output logic              m_tvalid_o,
   output logic              m_tlast_o,
   input  logic              m_tready_i
);

   logic [DATA_W-1:0] data_q [2];
   logic [1:0]        last_q;
   logic              wrPtr_q, wrPtr_d;
   logic              rdPtr_q, rdPtr_d;
   logic [1:0]        count_q, count_d;
   logic              doPush, doPop;

   always_comb begin
      doPop   = (count_q != 2'd0) && m_tready_i;
      doPush  = push_i && ((count_q != 2'd2) || m_tready_i);
      wrPtr_d = wrPtr_q ^ doPush;
      rdPtr_d = rdPtr_q ^ doPop;
      count_d = count_q;
      if (doPush && !doPop) begin
         count_d = count_q + 2'd1;
      end else if (doPop && !doPush) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         data_q[0] <= '0;
         data_q[1] <= '0;
         last_q    <= '0;
         wrPtr_q   <= 1'b0;
         rdPtr_q   <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (doPush) begin
            data_q[wrPtr_q] <= data_i;
            last_q[wrPtr_q] <= last_i;
         end
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // tlast is gated so a stale flag never shows once the buffer has drained.
   assign m_tvalid_o = (count_q != 2'd0);
   assign m_tdata_o  = data_q[rdPtr_q];
   assign m_tlast_o  = m_tvalid_o && last_q[rdPtr_q];
   assign full_o     = (count_q == 2'd2);
   assign level_o    = count_q;

endmodule

// File: rtl/echo_capture_window.sv
// Ping-triggered echo capture: blank cfg_delay samples, then pack cfg_len
// words of two samples each onto an AXI-Stream port, counting dropped words.
module echo_capture_window #(
   parameter int SAMPLE_W = 16,
   parameter int DELAY_W  = 16,
   parameter int LEN_W    = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [SAMPLE_W-1:0]   adc_data,
   input  logic                  adc_valid,
   input  logic                  trig,
   input  logic [DELAY_W-1:0]    cfg_delay,
   input  logic [LEN_W-1:0]      cfg_len,
   output logic [2*SAMPLE_W-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           ovf_cnt
);

   import sonar_capture_pkg::*;

   cap_state_t            state_q, state_d;
   logic [DELAY_W-1:0]    delayCfg_q, delayCfg_d, delayCnt_q, delayCnt_d, delayCntInc;
   logic [LEN_W-1:0]      lenCfg_q, lenCfg_d, wordCnt_q, wordCnt_d, wordCntInc;
   logic                  phase_q, phase_d;
   logic [SAMPLE_W-1:0]   loSample_q, loSample_d;
   logic                  wordValid_q, wordValid_d;
   logic                  wordLast_q, wordLast_d;
   logic [2*SAMPLE_W-1:0] wordData_q, wordData_d;
   logic [15:0]           ovfCnt_q, ovfCnt_d;
   logic                  done_q, done_d;
   logic                  bufFull, bufAccept, bufPush, flushDone, trigAccept, wordFormed;
   logic [1:0]            bufLevel;

   assign delayCntInc = delayCnt_q + DELAY_W'(1);
   assign wordCntInc  = wordCnt_q + LEN_W'(1);
   assign trigAccept  = (state_q == IDLE) && trig;
   assign wordFormed  = (state_q == CAPTURE) && adc_valid && phase_q;
   assign bufAccept   = !bufFull || m_tready;
   assign bufPush     = wordValid_q && bufAccept;
   // Drained once nothing is pending and the buffer is, or is about to be, empty.
   assign flushDone   = !wordValid_q &&
                        ((bufLevel == 2'd0) || ((bufLevel == 2'd1) && m_tready));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (trig) state_d = (cfg_delay == '0) ? CAPTURE : DELAY;
         DELAY:   if (adc_valid && (delayCntInc == delayCfg_q)) state_d = CAPTURE;
         CAPTURE: if (wordFormed && (wordCntInc == lenCfg_q)) state_d = FLUSH;
         FLUSH:   if (flushDone) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q != IDLE);
      done    = done_q;
      ovf_cnt = ovfCnt_q;
   end

   always_comb begin
      delayCfg_d  = delayCfg_q;
      lenCfg_d    = lenCfg_q;
      delayCnt_d  = delayCnt_q;
      wordCnt_d   = wordCnt_q;
      phase_d     = phase_q;
      loSample_d  = loSample_q;
      wordValid_d = wordValid_q;
      wordLast_d  = wordLast_q;
      wordData_d  = wordData_q;
      ovfCnt_d    = ovfCnt_q;
      done_d      = (state_q == FLUSH) && flushDone;

      if (trigAccept) begin
         delayCfg_d = cfg_delay;
         lenCfg_d   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
         delayCnt_d = '0;
         wordCnt_d  = '0;
         phase_d    = 1'b0;
         ovfCnt_d   = '0;
      end

      if ((state_q == DELAY) && adc_valid) begin
         delayCnt_d = delayCntInc;
      end

      if ((state_q == CAPTURE) && adc_valid) begin
         phase_d = ~phase_q;
         if (!phase_q) begin
            loSample_d = adc_data;
         end
      end

      // The final word waits in the word register; earlier words are dropped.
      if (wordValid_q) begin
         if (bufAccept) begin
            wordValid_d = 1'b0;
         end else if (!wordLast_q) begin
            wordValid_d = 1'b0;
            if (ovfCnt_q != OVF_MAX) begin
               ovfCnt_d = ovfCnt_q + 16'd1;
            end
         end
      end

      if (wordFormed) begin
         wordValid_d = 1'b1;
         wordData_d  = {adc_data, loSample_q};
         wordLast_d  = (wordCntInc == lenCfg_q);
         wordCnt_d   = wordCntInc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         delayCfg_q  <= '0;
         lenCfg_q    <= '0;
         delayCnt_q  <= '0;
         wordCnt_q   <= '0;
         phase_q     <= 1'b0;
         loSample_q  <= '0;
         wordValid_q <= 1'b0;
         wordLast_q  <= 1'b0;
         wordData_q  <= '0;
         ovfCnt_q    <= '0;
         done_q      <= 1'b0;
      end else begin
         delayCfg_q  <= delayCfg_d;
         lenCfg_q    <= lenCfg_d;
         delayCnt_q  <= delayCnt_d;
         wordCnt_q   <= wordCnt_d;
         phase_q     <= phase_d;
         loSample_q  <= loSample_d;
         wordValid_q <= wordValid_d;
         wordLast_q  <= wordLast_d;
         wordData_q  <= wordData_d;
         ovfCnt_q    <= ovfCnt_d;
         done_q      <= done_d;
      end
   end

   axis_buf2 #(
      .DATA_W (2*SAMPLE_W)
   ) u_buf (
      .clk        (clk),
      .rstn       (rstn),
      .push_i     (bufPush),
      .data_i     (wordData_q),
      .last_i     (wordLast_q),
      .full_o     (bufFull),
      .level_o    (bufLevel),
      .m_tdata_o  (m_tdata),
      .m_tvalid_o (m_tvalid),
      .m_tlast_o  (m_tlast),
      .m_tready_i (m_tready)
   );

endmodule

// File: tb/tb_echo_capture_window.sv
// Directed self-checking bench for echo_capture_window: inputs change 1ns after
// the rising edge, outputs and stream handshakes are observed on the falling edge.
module tb_echo_capture_window;

   logic        clk       = 1'b0;
   logic        rstn      = 1'b0;
   logic [15:0] adc_data  = '0;
   logic        adc_valid = 1'b0;
   logic        trig      = 1'b0;
   logic [15:0] cfg_delay = '0;
   logic [15:0] cfg_len   = '0;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready  = 1'b0;
   logic        m_tlast;
   logic        busy;
   logic        done;
   logic [15:0] ovf_cnt;

   int errors    = 0;
   int checks    = 0;
   int doneCount = 0;
   logic [31:0] capData [$];
   logic        capLast [$];

   always #5 clk = ~clk;

   echo_capture_window dut (
      .clk       (clk),
      .rstn      (rstn),
      .adc_data  (adc_data),
      .adc_valid (adc_valid),
      .trig      (trig),
      .cfg_delay (cfg_delay),
      .cfg_len   (cfg_len),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .busy      (busy),
      .done      (done),
      .ovf_cnt   (ovf_cnt)
   );

   // Stream monitor: every accepted word and every done pulse is logged.
   always @(negedge clk) begin
      if (rstn && m_tvalid && m_tready) begin
         capData.push_back(m_tdata);
         capLast.push_back(m_tlast);
      end
      if (rstn && done) doneCount++;
   end

   task automatic driveCycle(input logic v, input logic [15:0] d, input logic t);
      adc_valid = v;
      adc_data  = d;
      trig      = t;
      @(posedge clk);
      #1;
      adc_valid = 1'b0;
      trig      = 1'b0;
   endtask

   task automatic doTrig(input logic [15:0] d, input logic [15:0] l);
      cfg_delay = d;
      cfg_len   = l;
      driveCycle(1'b0, 16'h0000, 1'b1);
   endtask

   task automatic waitIdle(input int budget, input string name);
      int n;
      n = 0;
      while (busy === 1'b1 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_timeout busy=%0b still set after %0d cycles, required 0", name, busy, budget);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got %0b exp 0", m_tvalid); end
      checks++; if (m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast got %0b exp 0", m_tlast); end
      checks++; if (m_tdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_tdata got %h exp 0", m_tdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b exp 0", done); end
      checks++; if (ovf_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_ovf got %h exp 0", ovf_cnt); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int base, dbase;
      logic [31:0] expW [3];
      expW[0] = 32'h00050004;
      expW[1] = 32'h00070006;
      expW[2] = 32'h00090008;
      base  = capData.size();
      dbase = doneCount;
      m_tready = 1'b1;
      doTrig(16'd4, 16'd3);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %0b exp 1", busy); end
      for (int i = 0; i < 16; i++) driveCycle(1'b1, 16'(i), 1'b0);
      waitIdle(50, "basic");
      checks++; if (capData.size() - base != 3) begin errors++; $display("[TB] FAIL basic_count got %0d exp 3", capData.size() - base); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (capData[base+i] !== expW[i] || capLast[base+i] !== (i == 2)) begin
            errors++;
            $display("[TB] FAIL basic_word%0d got %h last %0b exp %h last %0b", i, capData[base+i], capLast[base+i], expW[i], (i == 2));
         end
      end
      checks++; if (doneCount - dbase != 1) begin errors++; $display("[TB] FAIL basic_done got %0d pulses exp 1", doneCount - dbase); end
      checks++; if (ovf_cnt !== 16'h0) begin errors++; $display("[TB] FAIL basic_ovf got %h exp 0", ovf_cnt); end
   endtask

   task automatic test_zero_config();
      int base, dbase;
      base  = capData.size();
      dbase = doneCount;
      m_tready = 1'b0;
      doTrig(16'd0, 16'd0);
      driveCycle(1'b1, 16'hBEEF, 1'b0);
      driveCycle(1'b1, 16'h1234, 1'b0);
      @(negedge clk);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL zero_latency_early got %0b exp 0", m_tvalid); end
      @(negedge clk);
      checks++; if (m_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL zero_latency_valid got %0b exp 1", m_tvalid); end
      checks++; if (m_tdata !== 32'h1234BEEF || m_tlast !== 1'b1) begin errors++; $display("[TB] FAIL zero_word got %h last %0b exp 1234beef last 1", m_tdata, m_tlast); end
      @(posedge clk);
      #1;
      driveCycle(1'b1, 16'h5555, 1'b0);
      driveCycle(1'b1, 16'h6666, 1'b0);
      m_tready = 1'b1;
      waitIdle(20, "zero");
      checks++; if (capData.size() - base != 1) begin errors++; $display("[TB] FAIL zero_count got %0d exp 1", capData.size() - base); end
      checks++; if (capData[base] !== 32'h1234BEEF || capLast[base] !== 1'b1) begin errors++; $display("[TB] FAIL zero_delivered got %h last %0b exp 1234beef last 1", capData[base], capLast[base]); end
      checks++; if (doneCount - dbase != 1) begin errors++; $display("[TB] FAIL zero_done got %0d pulses exp 1", doneCount - dbase); end
   endtask

   task automatic test_backpressure();
      int base;
      logic [31:0] expW [3];
      expW[0] = 32'h01010100;
      expW[1] = 32'h01030102;
      expW[2] = 32'h010B010A;
      base = capData.size();
      m_tready = 1'b0;
      doTrig(16'd0, 16'd6);
      for (int i = 0; i < 12; i++) driveCycle(1'b1, 16'h0100 + 16'(i), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ovf_cnt !== 16'd3) begin errors++; $display("[TB] FAIL bp_ovf_held got %0d exp 3", ovf_cnt); end
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== expW[0]) begin errors++; $display("[TB] FAIL bp_stable got valid %0b data %h exp valid 1 data %h", m_tvalid, m_tdata, expW[0]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy got %0b exp 1", busy); end
      m_tready = 1'b1;
      waitIdle(20, "bp");
      checks++; if (capData.size() - base != 3) begin errors++; $display("[TB] FAIL bp_count got %0d exp 3", capData.size() - base); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (capData[base+i] !== expW[i] || capLast[base+i] !== (i == 2)) begin
            errors++;
            $display("[TB] FAIL bp_word%0d got %h last %0b exp %h last %0b", i, capData[base+i], capLast[base+i], expW[i], (i == 2));
         end
      end
      checks++; if (ovf_cnt !== 16'd3) begin errors++; $display("[TB] FAIL bp_ovf_final got %0d exp 3", ovf_cnt); end
   endtask

   task automatic test_retrigger_gaps();
      int base, dbase;
      base  = capData.size();
      dbase = doneCount;
      m_tready = 1'b1;
      doTrig(16'd2, 16'd2);
      checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("[TB] FAIL retrig_ovf_clear got %0d exp 0", ovf_cnt); end
      driveCycle(1'b1, 16'h00A0, 1'b0);
      driveCycle(1'b1, 16'h00A1, 1'b0);
      driveCycle(1'b1, 16'h0011, 1'b0);
      cfg_delay = 16'd0;
      cfg_len   = 16'd1;
      driveCycle(1'b0, 16'h00FF, 1'b1);
      driveCycle(1'b0, 16'h00EE, 1'b0);
      driveCycle(1'b1, 16'h0022, 1'b0);
      driveCycle(1'b1, 16'h0033, 1'b0);
      driveCycle(1'b0, 16'h00DD, 1'b0);
      driveCycle(1'b0, 16'h00CC, 1'b0);
      driveCycle(1'b1, 16'h0044, 1'b0);
      waitIdle(20, "retrig");
      checks++; if (capData.size() - base != 2) begin errors++; $display("[TB] FAIL retrig_count got %0d exp 2", capData.size() - base); end
      checks++; if (capData[base] !== 32'h00220011 || capLast[base] !== 1'b0) begin errors++; $display("[TB] FAIL retrig_word0 got %h last %0b exp 00220011 last 0", capData[base], capLast[base]); end
      checks++; if (capData[base+1] !== 32'h00440033 || capLast[base+1] !== 1'b1) begin errors++; $display("[TB] FAIL retrig_word1 got %h last %0b exp 00440033 last 1", capData[base+1], capLast[base+1]); end
      checks++; if (doneCount - dbase != 1) begin errors++; $display("[TB] FAIL retrig_done got %0d pulses exp 1", doneCount - dbase); end
   endtask

   task automatic test_reset_mid_window();
      int base;
      base = capData.size();
      m_tready = 1'b1;
      doTrig(16'd0, 16'd4);
      for (int i = 0; i < 4; i++) driveCycle(1'b1, 16'h0050 + 16'(i), 1'b0);
      checks++; if (capData.size() - base != 1 || capData[base] !== 32'h00510050 || capLast[base] !== 1'b0) begin
         errors++; $display("[TB] FAIL midrst_first got %0d words, %h last %0b exp 1 word 00510050 last 0", capData.size() - base, capData[base], capLast[base]);
      end
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'h0) begin errors++; $display("[TB] FAIL midrst_stream got valid %0b last %0b data %h exp 0 0 0", m_tvalid, m_tlast, m_tdata); end
      checks++; if (busy !== 1'b0 || done !== 1'b0 || ovf_cnt !== 16'h0) begin errors++; $display("[TB] FAIL midrst_status got busy %0b done %0b ovf %h exp 0 0 0", busy, done, ovf_cnt); end
      @(posedge clk);
      #1;
      base = capData.size();
      doTrig(16'd1, 16'd1);
      driveCycle(1'b1, 16'h0060, 1'b0);
      driveCycle(1'b1, 16'h0061, 1'b0);
      driveCycle(1'b1, 16'h0062, 1'b0);
      waitIdle(20, "midrst");
      checks++; if (capData.size() - base != 1 || capData[base] !== 32'h00620061 || capLast[base] !== 1'b1) begin
         errors++; $display("[TB] FAIL midrst_rewindow got %0d words, %h last %0b exp 1 word 00620061 last 1", capData.size() - base, capData[base], capLast[base]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_config();
      test_backpressure();
      test_retrigger_gaps();
      test_reset_mid_window();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
